// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux tree: steps the select, waits DWELL cycles
// per channel, captures the tree output and publishes a 4-bit sample word.
module mux_scan_ctrl #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       mux_in,
    output logic [1:0] sel,
    output logic [3:0] sample,
    output logic       valid,
    output logic       busy
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]    r_sel, w_sel_nxt;
    logic [2:0]    r_shadow, w_shadow_nxt;
    logic [3:0]    r_sample, w_sample_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_sel    <= '0;
            r_shadow <= '0;
            r_sample <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sel    <= w_sel_nxt;
            r_shadow <= w_shadow_nxt;
            r_sample <= w_sample_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sel_nxt    = r_sel;
        w_shadow_nxt = r_shadow;
        w_sample_nxt = r_sample;
        unique case (r_state)
            S_IDLE: begin
                w_sel_nxt = '0;
                w_cnt_nxt = '0;
                if (start) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt != CNT_LAST) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end else begin
                    w_cnt_nxt = '0;
                    // last channel bypasses the shadow and lands directly in sample
                    if (r_sel != 2'd3) begin
                        w_shadow_nxt[r_sel] = mux_in;
                        w_sel_nxt           = r_sel + 2'd1;
                    end else begin
                        w_sample_nxt = {mux_in, r_shadow};
                        w_state_nxt  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_sel_nxt   = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = cont ? S_SETTLE : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign sel    = r_sel;
    assign sample = r_sample;
    assign valid  = (r_state == S_DONE);
    assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a modelled mux tree and a queue
// of expected sample words checked when valid pulses.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st4 = 1'b0, st1 = 1'b0;
    logic       ct4 = 1'b0, ct1 = 1'b0;
    logic [3:0] pat4 = 4'b0, pat1 = 4'b0;
    logic       mx4, mx1;
    logic [1:0] sel4, sel1;
    logic [3:0] smp4, smp1;
    logic       v4, v1, b4, b1;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    logic [3:0] q4[$];
    logic [3:0] q1[$];

    assign mx4 = pat4[sel4];
    assign mx1 = pat1[sel1];

    mux_scan_ctrl #(.DWELL(4)) dut4 (
        .clk(clk), .rst(rst), .start(st4), .cont(ct4), .mux_in(mx4),
        .sel(sel4), .sample(smp4), .valid(v4), .busy(b4)
    );

    mux_scan_ctrl #(.DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .start(st1), .cont(ct1), .mux_in(mx1),
        .sel(sel1), .sample(smp1), .valid(v1), .busy(b1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic pulse_start(input bit d1, output int e);
        @(negedge clk);
        if (d1) st1 = 1'b1;
        else    st4 = 1'b1;
        e = cyc + 1;
        @(negedge clk);
        st1 = 1'b0;
        st4 = 1'b0;
    endtask

    task automatic wait_valid(input bit d1, input string tag, input int exp_cyc);
        bit got = 0;
        logic [3:0] e;
        for (int n = 0; n < 200; n++) begin
            if (d1 ? v1 : v4) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
            if (d1 ? (q1.size() > 0) : (q4.size() > 0)) begin
                e = d1 ? q1.pop_front() : q4.pop_front();
                chk({tag, "_sample"}, 32'(d1 ? smp1 : smp4), 32'(e));
            end else begin
                chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            end
            @(negedge clk);
            chk({tag, "_vpulse"}, 32'(d1 ? v1 : v4), 32'd0);
        end
    endtask

    initial begin
        int e;
        int e2;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst4", {25'd0, sel4, smp4, v4, b4}, 32'd0);
            chk("rst1", {25'd0, sel1, smp1, v1, b1}, 32'd0);
        end

        pat4 = 4'b1010;
        q4.push_back(4'b1010);
        pulse_start(1'b0, e);
        for (int i = 0; i < 16; i++) begin
            wait_cyc(e + i);
            chk("sel_step", {28'd0, sel4, v4, b4}, {28'd0, 2'(i / 4), 1'b0, 1'b1});
        end
        wait_valid(1'b0, "single", e + 16);
        chk("idle_after", {29'd0, sel4, b4}, 32'd0);

        pat4 = 4'b0110;
        ct4  = 1'b1;
        q4.push_back(4'b0110);
        pulse_start(1'b0, e);
        wait_valid(1'b0, "cont1", e + 16);
        chk("cont_busy", 32'(b4), 32'd1);
        wait_cyc(e + 25);
        pat4 = 4'b1001;
        ct4  = 1'b0;
        q4.push_back((4'b1001 & 4'b1100) | (4'b0110 & 4'b0011));
        wait_valid(1'b0, "cont2", e + 33);
        chk("cont_idle", 32'(b4), 32'd0);

        pat4 = 4'b0011;
        q4.push_back(4'b0011);
        pulse_start(1'b0, e);
        for (int i = 0; i < 12; i++) begin
            st4 = 1'(i % 2);
            @(negedge clk);
        end
        st4 = 1'b0;
        wait_valid(1'b0, "restart_ign", e + 16);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_extra_v", 32'(v4), 32'd0);
        end

        pat4 = 4'b1100;
        pulse_start(1'b0, e);
        wait_cyc(e + 9);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst", {25'd0, sel4, smp4, v4, b4}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("rst_noval", {30'd0, v4, b4}, 32'd0);
        end
        q4.push_back(4'b1100);
        pulse_start(1'b0, e2);
        wait_valid(1'b0, "post_rst", e2 + 16);

        pat1 = 4'b1111;
        q1.push_back(4'b1111);
        pulse_start(1'b1, e);
        for (int i = 0; i < 4; i++) begin
            wait_cyc(e + i);
            chk("d1_sel", 32'(sel1), 32'(i));
        end
        wait_valid(1'b1, "dwell1", e + 4);
        chk("d1_idle", 32'(b1), 32'd0);
        chk("sb_drained", 32'(q4.size() + q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
